// File: rtl/i2c_master_if.sv
// Command/response handshake between a command issuer and the byte-level I2C master.
interface i2c_master_if;
    logic [1:0] cmd;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [7:0] tx_data;
    logic       tx_ack;
    logic [7:0] rx_data;
    logic       ack_in;
    logic       done;
    logic       bus_held;

    modport master (
        input  cmd, cmd_valid, tx_data, tx_ack,
        output cmd_ready, rx_data, ack_in, done, bus_held
    );

    modport slave (
        output cmd, cmd_valid, tx_data, tx_ack,
        input  cmd_ready, rx_data, ack_in, done, bus_held
    );
endinterface

// File: rtl/i2c_master.sv
// Byte-level open-drain I2C master executing START / WRITE / READ / STOP one at a time.
// Optional target clock stretching is enabled by defining I2C_MASTER_CLK_STRETCH_EN.
module i2c_master #(
    parameter int CLK_DIV = 25
) (
    input  logic         clk,
    input  logic         rst,
    inout  wire          scl,
    inout  wire          sda,
    i2c_master_if.master bus
);
    typedef enum logic [1:0] {IDLE, START, BIT, STOP} state_t;

    localparam logic [1:0] CMD_START = 2'b00;
    localparam logic [1:0] CMD_WRITE = 2'b01;
    localparam logic [1:0] CMD_READ  = 2'b10;
    localparam logic [7:0] Q_LAST    = 8'(CLK_DIV - 1);

    state_t     state, state_nx;
    logic [7:0] qcnt;
    logic [1:0] phase;
    logic [3:0] bitcnt;
    logic [1:0] cmd_q;
    logic [7:0] tx_q;
    logic       tx_ack_q;
    logic       rs_q;
    logic [8:0] shreg;
    logic [7:0] rx_q;
    logic       ack_in_q, done_q, held_q;
    logic       scl_hold, sda_hold, scl_drv, sda_drv, bit_low;
    logic       sda_s1, sda_s2;
    logic       accept, stall, q_end, last_q, sample;

    assign accept = (state == IDLE) && bus.cmd_valid;

`ifdef I2C_MASTER_CLK_STRETCH_EN
    logic scl_s1, scl_s2;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            scl_s1 <= 1'b1;
            scl_s2 <= 1'b1;
        end else begin
            scl_s1 <= scl;
            scl_s2 <= scl_s1;
        end
    end

    // Freeze at the start of Q1 until the released scl is actually seen high.
    assign stall = (phase == 2'd1) && (qcnt == 8'd0) && !scl_s2 &&
                   ((state == BIT) || (state == STOP) || ((state == START) && rs_q));
`else
    assign stall = 1'b0;
`endif

    assign q_end  = (qcnt == Q_LAST) && !stall;
    assign last_q = q_end && (phase == 2'd3);
    assign sample = (state == BIT) && (phase == 2'd2) && (qcnt == Q_LAST);

    // Slot 8 is the ACK slot; a 1 is always expressed by releasing the line.
    always_comb begin
        bit_low = 1'b0;
        if (bitcnt == 4'd8)
            bit_low = (cmd_q == CMD_READ) && !tx_ack_q;
        else
            bit_low = (cmd_q == CMD_WRITE) && !tx_q[3'd7 - bitcnt[2:0]];
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (bus.cmd == CMD_START)
                        state_nx = START;
                    else if (held_q)
                        state_nx = (bus.cmd == CMD_WRITE || bus.cmd == CMD_READ) ? BIT : STOP;
                end
            end
            START, STOP: if (last_q) state_nx = IDLE;
            BIT:         if (last_q && bitcnt == 4'd8) state_nx = IDLE;
            default:     state_nx = IDLE;
        endcase
    end

    // Line drive (1 = pull low); between commands the last levels are held.
    always_comb begin
        scl_drv = scl_hold;
        sda_drv = sda_hold;
        case (state)
            START: begin
                case (phase)
                    2'd0:    begin scl_drv = rs_q; sda_drv = 1'b0;  end
                    2'd1:    begin scl_drv = 1'b0; sda_drv = !rs_q; end
                    2'd2:    begin scl_drv = 1'b0; sda_drv = 1'b1;  end
                    default: begin scl_drv = 1'b1; sda_drv = 1'b1;  end
                endcase
            end
            BIT: begin
                scl_drv = (phase == 2'd0) || (phase == 2'd3);
                sda_drv = bit_low;
            end
            STOP: begin
                case (phase)
                    2'd0:    begin scl_drv = 1'b1; sda_drv = 1'b1; end
                    2'd1:    begin scl_drv = 1'b0; sda_drv = 1'b1; end
                    default: begin scl_drv = 1'b0; sda_drv = 1'b0; end
                endcase
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            qcnt     <= 8'd0;
            phase    <= 2'd0;
            bitcnt   <= 4'd0;
            scl_hold <= 1'b0;
            sda_hold <= 1'b0;
            sda_s1   <= 1'b1;
            sda_s2   <= 1'b1;
            rx_q     <= 8'h00;
            ack_in_q <= 1'b1;
            done_q   <= 1'b0;
            held_q   <= 1'b0;
        end else begin
            state    <= state_nx;
            scl_hold <= scl_drv;
            sda_hold <= sda_drv;
            sda_s1   <= sda;
            sda_s2   <= sda_s1;
            done_q   <= 1'b0;
            if (state == IDLE) begin
                qcnt   <= 8'd0;
                phase  <= 2'd0;
                bitcnt <= 4'd0;
            end else if (!stall) begin
                if (qcnt == Q_LAST) begin
                    qcnt  <= 8'd0;
                    phase <= phase + 2'd1;
                    if (phase == 2'd3)
                        bitcnt <= bitcnt + 4'd1;
                end else begin
                    qcnt <= qcnt + 8'd1;
                end
            end
            // Data commands and STOP on a free bus complete immediately.
            if (accept && !held_q && bus.cmd != CMD_START) begin
                done_q <= 1'b1;
                if (bus.cmd == CMD_WRITE)
                    ack_in_q <= 1'b1;
            end
            if (last_q) begin
                case (state)
                    START: begin held_q <= 1'b1; done_q <= 1'b1; end
                    STOP:  begin held_q <= 1'b0; done_q <= 1'b1; end
                    BIT: begin
                        if (bitcnt == 4'd8) begin
                            done_q <= 1'b1;
                            if (cmd_q == CMD_WRITE)
                                ack_in_q <= shreg[0];
                            else
                                rx_q <= shreg[8:1];
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            cmd_q    <= bus.cmd;
            tx_q     <= bus.tx_data;
            tx_ack_q <= bus.tx_ack;
            rs_q     <= held_q;
        end
        if (sample)
            shreg <= {shreg[7:0], sda_s2};
    end

    assign scl = scl_drv ? 1'b0 : 1'bz;
    assign sda = sda_drv ? 1'b0 : 1'bz;

    assign bus.cmd_ready = (state == IDLE);
    assign bus.rx_data   = rx_q;
    assign bus.ack_in    = ack_in_q;
    assign bus.done      = done_q;
    assign bus.bus_held  = held_q;
endmodule

// File: tb/tb_i2c_master.sv
// Directed bench for i2c_master: pulled-up bus, behavioural target at 7'h4a returning 8'h83.
module tb_i2c_master;
    localparam int D   = 4;
    localparam int L4  = 4 * D + 1;
    localparam int L36 = 36 * D + 1;
`ifdef I2C_MASTER_CLK_STRETCH_EN
    localparam int SLACK    = 40;
    localparam int HI_SLACK = 3;
`else
    localparam int SLACK    = 0;
    localparam int HI_SLACK = 0;
`endif
    localparam logic [1:0] C_START = 2'b00, C_WRITE = 2'b01, C_READ = 2'b10, C_STOP = 2'b11;

    logic clk = 1'b0;
    logic rst = 1'b0;
    wire  scl_w, sda_w;
    logic sl_low = 1'b0;
    logic st_low = 1'b0;

    pullup (scl_w);
    pullup (sda_w);
    assign sda_w = sl_low ? 1'b0 : 1'bz;
    assign scl_w = st_low ? 1'b0 : 1'bz;

    i2c_master_if bus ();
    i2c_master #(.CLK_DIV(D)) dut (.clk(clk), .rst(rst), .scl(scl_w), .sda(sda_w), .bus(bus));

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic check_rng(input string nm, input int act, input int lo, input int hi);
        n_cmp++;
        if (act < lo || act > hi) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d..%0d", nm, act, lo, hi);
        end
    endtask

    // Bus monitor: line sampled once per clock.
    logic p_scl = 1'b1, p_sda = 1'b1;
    int   edges = 0, start_cnt = 0, stop_cnt = 0;
    logic meas = 1'b0;
    int   hi_len = 0, hi_runs = 0, hi_bad = 0;

    always @(posedge clk) begin
        p_scl <= scl_w;
        p_sda <= sda_w;
        if (p_scl !== scl_w || p_sda !== sda_w) edges <= edges + 1;
        if (p_scl && scl_w && p_sda && !sda_w) start_cnt <= start_cnt + 1;
        if (p_scl && scl_w && !p_sda && sda_w) stop_cnt <= stop_cnt + 1;
        if (!meas) begin
            hi_len <= 0;
        end else if (scl_w) begin
            hi_len <= hi_len + 1;
        end else if (hi_len != 0) begin
            hi_runs <= hi_runs + 1;
            if (hi_len < 2 * D || hi_len > 2 * D + HI_SLACK) hi_bad <= hi_bad + 1;
            hi_len <= 0;
        end
    end

    // Target at 7'h4a: ACKs address and written bytes, streams 8'h83 on reads until NACKed.
    logic       slave_en = 1'b1;
    logic       active = 1'b0, addressed = 1'b0, rw = 1'b0, stop_tx = 1'b0, mack = 1'b1;
    int         bitn = 0, byte_idx = 0;
    logic [7:0] sh = 8'h00;
    logic [7:0] rdv = 8'h83;

    always @(posedge clk) begin
        if (!slave_en) begin
            active <= 1'b0;
            sl_low <= 1'b0;
        end else if (p_scl && scl_w && p_sda && !sda_w) begin
            active <= 1'b1; bitn <= 0; byte_idx <= 0;
            addressed <= 1'b0; rw <= 1'b0; stop_tx <= 1'b0; sl_low <= 1'b0;
        end else if (p_scl && scl_w && !p_sda && sda_w) begin
            active <= 1'b0;
            sl_low <= 1'b0;
        end else if (active && !p_scl && scl_w) begin
            if (bitn < 8) begin
                sh <= {sh[6:0], sda_w};
            end else if (bitn == 8 && rw && byte_idx > 0) begin
                mack <= sda_w;
                if (sda_w) stop_tx <= 1'b1;
            end
            bitn <= bitn + 1;
        end else if (active && p_scl && !scl_w) begin
            if (bitn == 9) begin
                bitn     <= 0;
                byte_idx <= byte_idx + 1;
                sl_low   <= addressed && rw && !stop_tx && !rdv[7];
            end else if (bitn == 8) begin
                if (byte_idx == 0) begin
                    addressed <= (sh[7:1] == 7'h4a);
                    rw        <= sh[0];
                    sl_low    <= (sh[7:1] == 7'h4a);
                end else begin
                    sl_low <= addressed && !rw;
                end
            end else begin
                sl_low <= addressed && rw && byte_idx > 0 && !stop_tx && !rdv[7 - bitn];
            end
        end
    end

    // Stretcher: after the third scl rise of an armed byte, hold scl low for 100 clocks.
    logic st_arm = 1'b0, st_done = 1'b0;
    int   st_rises = 0, st_cnt = 0;

    always @(posedge clk) begin
        if (!st_arm) begin
            st_rises <= 0; st_cnt <= 0; st_low <= 1'b0; st_done <= 1'b0;
        end else begin
            if (!p_scl && scl_w) st_rises <= st_rises + 1;
            if (st_cnt > 0) begin
                st_cnt <= st_cnt - 1;
                if (st_cnt == 1) st_low <= 1'b0;
            end else if (st_rises == 3 && p_scl && !scl_w && !st_done) begin
                st_low <= 1'b1; st_cnt <= 100; st_done <= 1'b1;
            end
        end
    end

    // Issue one command, scramble inputs after acceptance, poke cmd_valid while busy,
    // and return the number of cycles from the accepting edge to the done cycle.
    task automatic run_cmd(input logic [1:0] c, input logic [7:0] d, input logic a, output int lat);
        @(negedge clk);
        bus.cmd = c; bus.tx_data = d; bus.tx_ack = a; bus.cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0; bus.cmd = c ^ 2'b01; bus.tx_data = ~d; bus.tx_ack = ~a;
        meas = 1'b1;
        lat = 0;
        while (lat < 400) begin
            @(negedge clk);
            lat++;
            if (bus.done) break;
            if (lat == 3) begin bus.cmd = C_STOP; bus.cmd_valid = 1'b1; end
            if (lat == 5) bus.cmd_valid = 1'b0;
        end
        bus.cmd_valid = 1'b0;
        meas = 1'b0;
    endtask

    typedef struct {
        logic [1:0] c;
        logic [7:0] d;
        logic       a;
        int         lat;
        logic       chk_ack;
        logic       exp_ack;
        logic       chk_rx;
        logic [7:0] exp_rx;
        logic       chk_mack;
        logic       exp_mack;
        logic       quiet;
        logic       hi;
        logic       exp_held;
    } vec_t;

    vec_t tbl[17];

    function automatic vec_t mk(input logic [1:0] c, input logic [7:0] d, input logic a, input int lat,
                                input logic ca, input logic ea, input logic cr, input logic [7:0] er,
                                input logic cm, input logic em, input logic q, input logic hi,
                                input logic eh);
        vec_t v;
        v.c = c; v.d = d; v.a = a; v.lat = lat;
        v.chk_ack = ca; v.exp_ack = ea; v.chk_rx = cr; v.exp_rx = er;
        v.chk_mack = cm; v.exp_mack = em; v.quiet = q; v.hi = hi; v.exp_held = eh;
        return v;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, e0;
        bus.cmd = C_START; bus.cmd_valid = 1'b0; bus.tx_data = 8'h00; bus.tx_ack = 1'b1;

        //          cmd      data   ack   lat  ca ea  cr erx    cm em  q  hi held
        tbl[0]  = mk(C_START, 8'h00, 1'b0, L4,  0, 0,  0, 8'h00, 0, 0,  0, 0, 1);
        tbl[1]  = mk(C_WRITE, 8'h94, 1'b0, L36, 1, 0,  0, 8'h00, 0, 0,  0, 1, 1);
        tbl[2]  = mk(C_STOP,  8'h00, 1'b0, L4,  0, 0,  0, 8'h00, 0, 0,  0, 0, 0);
        tbl[3]  = mk(C_START, 8'h00, 1'b0, L4,  0, 0,  0, 8'h00, 0, 0,  0, 0, 1);
        tbl[4]  = mk(C_WRITE, 8'h96, 1'b0, L36, 1, 1,  0, 8'h00, 0, 0,  0, 1, 1);
        tbl[5]  = mk(C_STOP,  8'h00, 1'b0, L4,  0, 0,  0, 8'h00, 0, 0,  0, 0, 0);
        tbl[6]  = mk(C_START, 8'h00, 1'b0, L4,  0, 0,  0, 8'h00, 0, 0,  0, 0, 1);
        tbl[7]  = mk(C_WRITE, 8'h94, 1'b0, L36, 1, 0,  0, 8'h00, 0, 0,  0, 0, 1);
        tbl[8]  = mk(C_WRITE, 8'h10, 1'b0, L36, 1, 0,  0, 8'h00, 0, 0,  0, 0, 1);
        tbl[9]  = mk(C_START, 8'h00, 1'b0, L4,  0, 0,  0, 8'h00, 0, 0,  0, 0, 1);
        tbl[10] = mk(C_WRITE, 8'h95, 1'b0, L36, 1, 0,  0, 8'h00, 0, 0,  0, 0, 1);
        tbl[11] = mk(C_READ,  8'h00, 1'b0, L36, 0, 0,  1, 8'h83, 1, 0,  0, 1, 1);
        tbl[12] = mk(C_READ,  8'h00, 1'b1, L36, 0, 0,  1, 8'h83, 1, 1,  0, 0, 1);
        tbl[13] = mk(C_STOP,  8'h00, 1'b0, L4,  0, 0,  0, 8'h00, 0, 0,  0, 0, 0);
        tbl[14] = mk(C_READ,  8'h00, 1'b0, 1,   0, 0,  1, 8'h83, 0, 0,  1, 0, 0);
        tbl[15] = mk(C_STOP,  8'h00, 1'b0, 1,   0, 0,  0, 8'h00, 0, 0,  1, 0, 0);
        tbl[16] = mk(C_WRITE, 8'h55, 1'b0, 1,   1, 1,  0, 8'h00, 0, 0,  1, 0, 0);

        repeat (3) @(negedge clk);
        check("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        check("rst_done",      32'(bus.done),      32'd0);
        check("rst_bus_held",  32'(bus.bus_held),  32'd0);
        check("rst_rx_data",   32'(bus.rx_data),   32'h00);
        check("rst_ack_in",    32'(bus.ack_in),    32'd1);
        check("rst_scl",       32'(scl_w),         32'd1);
        check("rst_sda",       32'(sda_w),         32'd1);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 17; i++) begin
            e0 = edges;
            hi_runs = 0;
            hi_bad  = 0;
            run_cmd(tbl[i].c, tbl[i].d, tbl[i].a, lat);
            check_rng($sformatf("row%0d_latency", i), lat, tbl[i].lat, tbl[i].lat + SLACK);
            check($sformatf("row%0d_bus_held", i), 32'(bus.bus_held), 32'(tbl[i].exp_held));
            check($sformatf("row%0d_cmd_ready", i), 32'(bus.cmd_ready), 32'd1);
            if (tbl[i].chk_ack)
                check($sformatf("row%0d_ack_in", i), 32'(bus.ack_in), 32'(tbl[i].exp_ack));
            if (tbl[i].chk_rx)
                check($sformatf("row%0d_rx_data", i), 32'(bus.rx_data), 32'(tbl[i].exp_rx));
            if (tbl[i].chk_mack)
                check($sformatf("row%0d_master_ack_slot", i), 32'(mack), 32'(tbl[i].exp_mack));
            if (tbl[i].quiet) begin
                check($sformatf("row%0d_bus_quiet", i), 32'(edges - e0), 32'd0);
                check($sformatf("row%0d_scl_released", i), 32'(scl_w), 32'd1);
                check($sformatf("row%0d_sda_released", i), 32'(sda_w), 32'd1);
            end
            if (tbl[i].hi) begin
                check($sformatf("row%0d_scl_high_runs", i), 32'(hi_runs), 32'd9);
                check($sformatf("row%0d_scl_high_width", i), 32'(hi_bad), 32'd0);
            end
            @(negedge clk);
            check($sformatf("row%0d_done_one_cycle", i), 32'(bus.done), 32'd0);
        end
        check("start_conditions", 32'(start_cnt), 32'd4);
        check("stop_conditions",  32'(stop_cnt),  32'd3);

        // Asynchronous reset in the middle of a byte.
        slave_en = 1'b0;
        run_cmd(C_START, 8'h00, 1'b0, lat);
        check_rng("mid_start_latency", lat, L4, L4 + SLACK);
        @(negedge clk);
        bus.cmd = C_WRITE; bus.tx_data = 8'h00; bus.cmd_valid = 1'b1;
        @(posedge clk);
        #1 bus.cmd_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("mid_pre_scl_low", 32'(scl_w), 32'd0);
        check("mid_pre_sda_low", 32'(sda_w), 32'd0);
        rst = 1'b0;
        #1;
        check("mid_rst_scl_release", 32'(scl_w), 32'd1);
        check("mid_rst_sda_release", 32'(sda_w), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        check("mid_rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        check("mid_rst_bus_held",  32'(bus.bus_held),  32'd0);
        check("mid_rst_done",      32'(bus.done),      32'd0);
        repeat (3) @(negedge clk);
        check("post_rst_done",      32'(bus.done),      32'd0);
        check("post_rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);

        // Target stretches scl for 100 clocks during bit 3.
        run_cmd(C_START, 8'h00, 1'b0, lat);
        check_rng("st_start_latency", lat, L4, L4 + SLACK);
        st_arm = 1'b1;
        hi_runs = 0;
        hi_bad  = 0;
        run_cmd(C_WRITE, 8'h55, 1'b0, lat);
`ifdef I2C_MASTER_CLK_STRETCH_EN
        check_rng("st_write_latency", lat, L36 + 80, L36 + 110);
        check("st_scl_high_width", 32'(hi_bad), 32'd0);
`else
        check_rng("st_write_latency", lat, L36, L36);
`endif
        repeat (120) @(negedge clk);
        st_arm = 1'b0;
        run_cmd(C_STOP, 8'h00, 1'b0, lat);
        check_rng("st_stop_latency", lat, L4, L4 + SLACK);
        check("st_stop_bus_held", 32'(bus.bus_held), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
